// File: rtl/bist_sequencer.sv
// bist_sequencer: sequences a BIST session of NPASS passes, each pass being one INIT cycle,
// NCLOCK RUNNING cycles and one FINISH cycle, then parks in DONE with bist_end set.
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - asynchronous active-low reset
//   start     - session request, acted on at its rising edge in IDLE or DONE only
//   abort     - synchronous abort of an active session (INIT/RUNNING/FINISH)
//   init      - high in the INIT cycle of each pass
//   running   - high in each RUNNING cycle
//   toggle    - alternating strobe during RUNNING (0,1,0,...), 0 elsewhere
//   finish    - high in the FINISH cycle of each pass
//   pass_idx  - current pass index, 0..NPASS-1
//   busy      - high in INIT, RUNNING or FINISH
//   bist_end  - sticky: session completed normally
//   aborted   - sticky: session terminated by abort
module bist_sequencer #(
  parameter int unsigned NCLOCK = 10,
  parameter int unsigned NPASS  = 1,
  parameter int unsigned PASS_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              init,
  output logic              running,
  output logic              toggle,
  output logic              finish,
  output logic [PASS_W-1:0] pass_idx,
  output logic              busy,
  output logic              bist_end,
  output logic              aborted
);

  localparam int unsigned CntW = $clog2(NCLOCK) + 1;
  localparam logic [CntW-1:0]   CntLast  = CntW'(NCLOCK - 1);
  localparam logic [PASS_W-1:0] PassLast = PASS_W'(NPASS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRunning,
    StFinish,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              tog_q, tog_d;
  logic              bist_end_q, bist_end_d;
  logic              aborted_q, aborted_d;
  logic              start_q;
  logic              start_edge;
  logic              active;

  // start_q resets high so a start held through reset release is not seen as an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      pass_q     <= '0;
      tog_q      <= 1'b0;
      bist_end_q <= 1'b0;
      aborted_q  <= 1'b0;
      start_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pass_q     <= pass_d;
      tog_q      <= tog_d;
      bist_end_q <= bist_end_d;
      aborted_q  <= aborted_d;
      start_q    <= start;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    tog_d      = tog_q;
    bist_end_d = bist_end_q;
    aborted_d  = aborted_q;

    start_edge = start & ~start_q;
    active     = (state_q == StInit) || (state_q == StRunning) || (state_q == StFinish);

    // Abort outranks every transition, including FINISH->DONE on the last pass.
    if (active && abort) begin
      state_d    = StIdle;
      cnt_d      = '0;
      pass_d     = '0;
      tog_d      = 1'b0;
      bist_end_d = 1'b0;
      aborted_d  = 1'b1;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_edge) begin
            state_d    = StInit;
            pass_d     = '0;
            bist_end_d = 1'b0;
            aborted_d  = 1'b0;
          end
        end
        StInit: begin
          cnt_d   = '0;
          tog_d   = 1'b0;
          state_d = StRunning;
        end
        StRunning: begin
          tog_d = ~tog_q;
          if (cnt_q == CntLast) begin
            state_d = StFinish;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StFinish: begin
          tog_d = 1'b0;
          if (pass_q == PassLast) begin
            state_d    = StDone;
            bist_end_d = 1'b1;
          end else begin
            pass_d  = pass_q + 1'b1;
            state_d = StInit;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign init     = (state_q == StInit);
  assign running  = (state_q == StRunning);
  assign finish   = (state_q == StFinish);
  assign busy     = init | running | finish;
  assign toggle   = running & tog_q;
  assign pass_idx = pass_q;
  assign bist_end = bist_end_q;
  assign aborted  = aborted_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer with NCLOCK=4, NPASS=2.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_bist_sequencer;

  localparam int unsigned NCLOCK = 4;
  localparam int unsigned NPASS  = 2;
  localparam int unsigned PASS_W = 4;

  logic              clk;
  logic              reset;
  logic              start;
  logic              abort;
  logic              init;
  logic              running;
  logic              toggle;
  logic              finish;
  logic [PASS_W-1:0] pass_idx;
  logic              busy;
  logic              bist_end;
  logic              aborted;

  int vectors;
  int miscompares;

  bist_sequencer #(
    .NCLOCK(NCLOCK),
    .NPASS (NPASS),
    .PASS_W(PASS_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .init    (init),
    .running (running),
    .toggle  (toggle),
    .finish  (finish),
    .pass_idx(pass_idx),
    .busy    (busy),
    .bist_end(bist_end),
    .aborted (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector layout: {init, running, toggle, finish, busy, bist_end, aborted, pass_idx}
  function automatic logic [10:0] ev(input bit i, input bit r, input bit t, input bit f,
                                     input bit b, input bit be, input bit ab, input int p);
    logic [3:0] pp;
    pp = p[3:0];
    return {i, r, t, f, b, be, ab, pp};
  endfunction

  function automatic logic [10:0] obs();
    return {init, running, toggle, finish, busy, bist_end, aborted, pass_idx};
  endfunction

  task automatic chk(input string tag, input logic [10:0] exp);
    logic [10:0] o;
    o = obs();
    vectors++;
    assert (o === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b (init,run,tog,fin,busy,end,abt,pass)",
             tag, o, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called while in cycle 1 (INIT of pass 0); walks the whole session into DONE.
  task automatic check_session(input string tag, input bit glitch);
    for (int p = 0; p < int'(NPASS); p++) begin
      chk($sformatf("%s_init_p%0d", tag, p), ev(1, 0, 0, 0, 1, 0, 0, p));
      step();
      for (int k = 0; k < int'(NCLOCK); k++) begin
        if (glitch && p == 0 && k == 1) start = 1'b1;
        if (glitch && p == 0 && k == 2) start = 1'b0;
        chk($sformatf("%s_run_p%0d_c%0d", tag, p, k), ev(0, 1, k[0], 0, 1, 0, 0, p));
        step();
      end
      chk($sformatf("%s_fin_p%0d", tag, p), ev(0, 0, 0, 1, 1, 0, 0, p));
      step();
    end
    chk($sformatf("%s_done", tag), ev(0, 0, 0, 0, 0, 1, 0, NPASS - 1));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;

    // Reset state
    #2;
    chk("reset_async", ev(0, 0, 0, 0, 0, 0, 0, 0));
    step();
    step();
    reset = 1'b1;
    step();
    chk("idle_after_reset", ev(0, 0, 0, 0, 0, 0, 0, 0));

    // Basic session from a single start pulse
    start = 1'b1;
    step();
    start = 1'b0;
    check_session("s1", 1'b0);
    step();
    chk("s1_done_hold", ev(0, 0, 0, 0, 0, 1, 0, 1));

    // start held high for 30 cycles: exactly one session
    start = 1'b1;
    step();
    check_session("hold", 1'b0);
    for (int c = 0; c < 17; c++) step();
    chk("hold_done_still", ev(0, 0, 0, 0, 0, 1, 0, 1));
    start = 1'b0;
    step();
    chk("hold_released", ev(0, 0, 0, 0, 0, 1, 0, 1));
    start = 1'b1;
    step();
    start = 1'b0;
    check_session("rerun", 1'b0);

    // Abort during RUNNING cycle 2 of the second pass
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ab1_init", ev(1, 0, 0, 0, 1, 0, 0, 0));
    for (int c = 0; c < 9; c++) step();
    chk("ab1_run_p1_c2", ev(0, 1, 0, 0, 1, 0, 0, 1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab1_idle", ev(0, 0, 0, 0, 0, 0, 1, 0));
    step();
    chk("ab1_idle_sticky", ev(0, 0, 0, 0, 0, 0, 1, 0));

    // Abort coincident with FINISH of the last pass
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ab2_init", ev(1, 0, 0, 0, 1, 0, 0, 0));
    for (int c = 0; c < 11; c++) step();
    chk("ab2_fin_last", ev(0, 0, 0, 1, 1, 0, 0, 1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab2_idle", ev(0, 0, 0, 0, 0, 0, 1, 0));

    // Abort in IDLE with a simultaneous start edge: session proceeds
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check_session("idle_abort", 1'b0);

    // Abort in DONE is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("done_abort_ignored", ev(0, 0, 0, 0, 0, 1, 0, 1));

    // Reset mid-RUNNING with start held high
    start = 1'b1;
    step();
    chk("rst_init", ev(1, 0, 0, 0, 1, 0, 0, 0));
    step();
    step();
    step();
    chk("rst_run_c2", ev(0, 1, 0, 0, 1, 0, 0, 0));
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_mid", ev(0, 0, 0, 0, 0, 0, 0, 0));
    step();
    step();
    reset = 1'b1;
    step();
    chk("rst_release_hi", ev(0, 0, 0, 0, 0, 0, 0, 0));
    step();
    step();
    chk("rst_no_launch", ev(0, 0, 0, 0, 0, 0, 0, 0));
    start = 1'b0;
    step();
    chk("rst_start_low", ev(0, 0, 0, 0, 0, 0, 0, 0));

    // Start edge during busy is discarded; timing unchanged
    start = 1'b1;
    step();
    start = 1'b0;
    check_session("glitch", 1'b1);
    step();
    chk("glitch_done_hold", ev(0, 0, 0, 0, 0, 1, 0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
